// File: rtl/cpt_down_if.sv
// Bus bundle for cpt_down: count control/load inputs and count/status outputs.
// Latency: none (wires only); the counter registers every output it drives.
// Backpressure: none; control strobes are sampled every clock edge.
interface cpt_down_if #(
  parameter int WIDTH = 8
);
  logic             activate;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             zero;

  // Controller side: drives the strobes and load value, observes the counter.
  modport master (
    output activate, load, din,
    input  out, busy, zero
  );

  // Counter side.
  modport slave (
    input  activate, load, din,
    output out, busy, zero
  );
endinterface

// File: rtl/cpt_down.sv
// Loadable down-counter with IDLE/COUNT FSM and a registered terminal-count pulse.
// Latency: 1 cycle from load/activate to out/busy; zero is high the cycle after expiry.
// Backpressure: none; optional auto-reload compiled in with CPT_DOWN_RELOAD_EN.
module cpt_down #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       reset,
  cpt_down_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
`ifdef CPT_DOWN_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next state: load wins over activate; the decrement is only taken above 1,
  // so the count never wraps and an expiry is the only way out of 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zero_d  = 1'b0;
`ifdef CPT_DOWN_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      cnt_d   = bus.din;
      state_d = (bus.din != '0) ? COUNT : IDLE;
`ifdef CPT_DOWN_RELOAD_EN
      if (bus.din != '0) begin
        reload_d = bus.din;
      end
`endif
    end else if (state_q == COUNT && bus.activate) begin
      if (cnt_q == WIDTH'(1)) begin
        zero_d = 1'b1;
`ifdef CPT_DOWN_RELOAD_EN
        cnt_d   = reload_q;
        state_d = COUNT;
`else
        cnt_d   = '0;
        state_d = IDLE;
`endif
      end else if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
`ifdef CPT_DOWN_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
`ifdef CPT_DOWN_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.out  = cnt_q;
  assign bus.busy = (state_q == COUNT);
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_cpt_down.sv
// Self-checking bench for cpt_down: directed scenarios plus random traffic
// against a behavioural model of the counting rules (follows CPT_DOWN_RELOAD_EN).
module tb_cpt_down;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Reference model state: plain integers.
  int m_cnt;
  int m_run;
  int m_zero;
  int m_rel;

  cpt_down_if #(.WIDTH(W)) bus ();

  cpt_down #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_run  = 0;
    m_zero = 0;
    m_rel  = 0;
  endtask

  // One clock edge of the counting rules.
  task automatic model_step(input int act, input int ld, input int d);
    m_zero = 0;
    if (ld != 0) begin
      m_cnt = d;
      m_run = (d != 0);
      if (d != 0) m_rel = d;
    end else if (m_run != 0 && act != 0) begin
      if (m_cnt == 1) begin
        m_zero = 1;
`ifdef CPT_DOWN_RELOAD_EN
        m_cnt = m_rel;
`else
        m_cnt = 0;
        m_run = 0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"},  int'(bus.out),  m_cnt);
    check({tag, ".busy"}, int'(bus.busy), m_run);
    check({tag, ".zero"}, int'(bus.zero), m_zero);
  endtask

  // Drive inputs, take one edge, sample 1ns later against the model.
  task automatic cycle(input string tag, input int act, input int ld, input int d);
    bus.activate = act[0];
    bus.load     = ld[0];
    bus.din      = W'(d);
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(act, ld, d);
    #1;
    compare_all(tag);
  endtask

  // Pull reset low between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    reset        = 1'b0;
    bus.activate = 1'b0;
    bus.load     = 1'b0;
    bus.din      = '0;

    // Reset state.
    #2;
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_edge");
    reset = 1'b1;

    // Basic count: 3,2,1,0 (or back to 3 with reload).
    cycle("basic_load", 0, 1, 3);
    check("basic_load_lit", int'(bus.out), 3);
    for (int i = 0; i < 5; i++) cycle("basic_run", 1, 0, 0);
`ifndef CPT_DOWN_RELOAD_EN
    check("basic_end_lit", int'(bus.out), 0);
`endif

    // Hold: load 4, activate 1,0,0,1 -> 3,3,3,2.
    cycle("hold_load", 0, 1, 4);
    cycle("hold_a1", 1, 0, 0);
    cycle("hold_a0", 0, 0, 0);
    cycle("hold_a0b", 0, 0, 0);
    cycle("hold_a1b", 1, 0, 0);
    check("hold_lit", int'(bus.out), 2);

    // Load priority over activate at out=2.
    cycle("prio", 1, 1, 9);
    check("prio_lit", int'(bus.out), 9);

    // Idle, no wrap: load 0 then activate for 10 cycles.
    cycle("idle_load0", 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle("idle_act", 1, 0, 0);
    check("nowrap_lit", int'(bus.out), 0);

    // Expiry at count 1, then reload or stop.
    cycle("exp_load", 0, 1, 2);
    for (int i = 0; i < 4; i++) cycle("exp_run", 1, 0, 0);
`ifdef CPT_DOWN_RELOAD_EN
    check("reload_lit", int'(bus.out), 2);
`endif

    // Async reset mid-count, then no pulse afterwards.
    cycle("ar_load", 0, 1, 5);
    async_reset("ar");
    for (int i = 0; i < 3; i++) cycle("ar_after", 1, 0, 0);
    cycle("ar_first", 1, 1, 1);
    cycle("ar_expire", 1, 0, 0);

    // Random traffic biased toward small loads so expiries are frequent.
    for (int i = 0; i < 600; i++) begin
      int act, ld, d;
      act = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 7) == 0);
      d   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else cycle("rnd", act, ld, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpt_down.md
CPT_DOWN -- requirements
Module: cpt_down

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..16.
REQ-002 Port clk  input  1: single clock; all state changes occur on its rising edge.
REQ-003 Port reset  input  1: asynchronous, active-low reset.
REQ-004 Port activate  input  1: count enable, sampled on the rising edge of clk.
REQ-005 Port load  input  1: parallel-load strobe, sampled on the rising edge of clk.
REQ-006 Port din  input  WIDTH: load value.
REQ-007 Port out  output  WIDTH: current count, driven directly by a register.
REQ-008 Port busy  output  1: high while the FSM is in state COUNT.
REQ-009 Port zero  output  1: registered terminal-count pulse.

Function
REQ-010 The FSM SHALL have two states, IDLE and COUNT; busy SHALL be high exactly when the state is COUNT.
REQ-011 load=1 with din!=0 SHALL set out to din and the state to COUNT at the next edge, in either state.
REQ-012 load=1 with din=0 SHALL set out to 0 and the state to IDLE; zero SHALL NOT pulse.
REQ-013 load SHALL take priority over activate in the same cycle; no decrement SHALL occur in that cycle.
REQ-014 In COUNT with activate=1, load=0 and out>1, out SHALL decrement by 1 per edge.
REQ-015 In COUNT with activate=0 and load=0, out and the state SHALL hold.
REQ-016 Expiry is defined as the edge where the state is COUNT, activate=1, load=0 and out=1.
REQ-017 At expiry, out SHALL become 0, the state SHALL become IDLE, and zero SHALL be high for exactly the following cycle.
REQ-018 In IDLE with load=0, out SHALL hold and SHALL never wrap (0 never becomes 2^WIDTH-1).
REQ-019 At every edge that is not an expiry, zero SHALL return to 0; zero SHALL never be high for two consecutive cycles unless two expiries occur on consecutive edges.
REQ-020 Decrement arithmetic SHALL be WIDTH bits, unsigned.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for clk, force out=0, busy=0, zero=0, state=IDLE, and the reload register (if present) to 0.
REQ-022 Assertion of reset mid-count SHALL abort the count; no zero pulse SHALL be produced.
REQ-023 After reset deasserts, the first edge SHALL obey REQ-011..REQ-018 normally.

Configuration
REQ-024 Macro CPT_DOWN_RELOAD_EN SHALL compile in the auto-reload feature.
REQ-025 With CPT_DOWN_RELOAD_EN defined:
- Every load with din!=0 SHALL also capture din into a WIDTH-bit reload register.
- At expiry, out SHALL become the reload value instead of 0, and the state SHALL remain COUNT.
- zero SHALL still pulse for one cycle at expiry.
REQ-026 Without CPT_DOWN_RELOAD_EN, no reload register SHALL exist, and expiry SHALL behave as in REQ-017.

Verification
REQ-027 Async reset: out=5 in COUNT, drop reset between edges -> out=0, busy=0, zero=0 before the next edge; no zero pulse afterwards.
REQ-028 Basic count (reload off): load din=3, then activate=1 held -> out sequence 3,2,1,0; zero=1 only in the cycle out=0; busy falls in that same cycle; out stays 0 afterwards.
REQ-029 Hold: load 4, activate pattern 1,0,0,1 -> out 4,3,3,3,2; busy stays 1.
REQ-030 Load priority: out=2 in COUNT, load=1, din=9, activate=1 -> next out=9, no zero pulse.
REQ-031 Idle/no-wrap: out=0 in IDLE, activate=1 for 10 cycles -> out remains 0, zero remains 0; load din=0 -> no pulse, busy=0.
REQ-032 Reload on: load din=2, activate=1 held -> out 2,1,2,1,2; zero=1 in each cycle after a 1->2 transition; busy stays 1.
